// File: rtl/alarm_controller_pkg.sv
// Shared types and constants for the alarm controller: FSM state encoding,
// BCD field limits and display blink masks.
package alarm_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_RING     = 3'd3,
    ST_SNOOZE   = 3'd4
  } state_t;

  localparam int HOUR_MAX_TENS  = 2;
  localparam int HOUR_MAX_UNITS = 3;
  localparam int MIN_MAX_TENS   = 5;
  localparam int MIN_MAX_UNITS  = 9;

  localparam logic [1:0] DISP_NONE = 2'b00;
  localparam logic [1:0] DISP_HOUR = 2'b10;
  localparam logic [1:0] DISP_MIN  = 2'b01;

  function automatic logic is_set_state(input state_t st);
    logic r;
    case (st)
      ST_SET_HOUR: r = 1'b1;
      ST_SET_MIN:  r = 1'b1;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] disp_mask(input state_t st);
    logic [1:0] m;
    case (st)
      ST_SET_HOUR: m = DISP_HOUR;
      ST_SET_MIN:  m = DISP_MIN;
      default:     m = DISP_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alarm_controller_bcd_field_incr.sv
// Combinational next value of a two-digit BCD field, wrapping to 00 after
// the configured maximum (out-of-range values also wrap to 00).
module bcd_field_incr #(
  parameter int TENS_W    = 3,
  parameter int MAX_TENS  = 5,
  parameter int MAX_UNITS = 9
) (
  input  logic [3:0]        units,
  input  logic [TENS_W-1:0] tens,
  output logic [3:0]        next_units,
  output logic [TENS_W-1:0] next_tens
);

  logic at_max_s;

  // Detect the terminal value (or anything beyond it) of the field.
  always_comb begin
    at_max_s = 1'b0;
    if (tens > TENS_W'(MAX_TENS)) begin
      at_max_s = 1'b1;
    end else if ((tens == TENS_W'(MAX_TENS)) && (units >= 4'(MAX_UNITS))) begin
      at_max_s = 1'b1;
    end else begin
      at_max_s = 1'b0;
    end
  end

  // Increment with decimal carry from units into tens.
  always_comb begin
    next_units = 4'd0;
    next_tens  = {TENS_W{1'b0}};
    if (at_max_s) begin
      next_units = 4'd0;
      next_tens  = {TENS_W{1'b0}};
    end else if (units >= 4'd9) begin
      next_units = 4'd0;
      next_tens  = tens + {{(TENS_W-1){1'b0}}, 1'b1};
    end else begin
      next_units = units + 4'd1;
      next_tens  = tens;
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm sequencing for the FPGA clock: alarm HH:MM editing, arming, ringing,
// snooze and display steering, all outputs registered.
module alarm_controller
  import alarm_controller_pkg::*;
#(
  parameter int RING_SECONDS    = 60,
  parameter int SNOOZE_SECONDS  = 300,
  parameter int SET_TIMEOUT_SEC = 10
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Enable_1Hz,
  input  logic       i_Released_Button_Alarm,
  input  logic       i_Released_Button_Up,
  input  logic       i_Clock_Mode_Idle,
  input  logic [3:0] i_Units_Sec,
  input  logic [2:0] i_Tens_Sec,
  input  logic [3:0] i_Units_Min,
  input  logic [2:0] i_Tens_Min,
  input  logic [3:0] i_Units_Hour,
  input  logic [1:0] i_Tens_Hour,
  output logic [3:0] o_Alarm_Units_Min,
  output logic [2:0] o_Alarm_Tens_Min,
  output logic [3:0] o_Alarm_Units_Hour,
  output logic [1:0] o_Alarm_Tens_Hour,
  output logic       o_Display_Select_Alarm,
  output logic [1:0] o_Display_Enable_Digits,
  output logic       o_Alarm_Armed,
  output logic       o_Buzzer_Enable
);

  localparam int IDLE_W   = $clog2(SET_TIMEOUT_SEC + 1);
  localparam int RING_W   = $clog2(RING_SECONDS + 1);
  localparam int SNOOZE_W = $clog2(SNOOZE_SECONDS + 1);

  state_t               state_r, state_s;
  logic [IDLE_W-1:0]    idle_cnt_r, idle_cnt_s;
  logic [RING_W-1:0]    ring_cnt_r, ring_cnt_s;
  logic [SNOOZE_W-1:0]  snooze_cnt_r, snooze_cnt_s;
  logic                 match_prev_r;
  logic                 match_s, match_rise_s;
  logic                 armed_s;
  logic [3:0]           units_hour_s, units_min_s;
  logic [1:0]           tens_hour_s;
  logic [2:0]           tens_min_s;
  logic [3:0]           hour_units_inc_s, min_units_inc_s;
  logic [1:0]           hour_tens_inc_s;
  logic [2:0]           min_tens_inc_s;

  bcd_field_incr #(
    .TENS_W   (2),
    .MAX_TENS (HOUR_MAX_TENS),
    .MAX_UNITS(HOUR_MAX_UNITS)
  ) u_hour_incr (
    .units     (o_Alarm_Units_Hour),
    .tens      (o_Alarm_Tens_Hour),
    .next_units(hour_units_inc_s),
    .next_tens (hour_tens_inc_s)
  );

  bcd_field_incr #(
    .TENS_W   (3),
    .MAX_TENS (MIN_MAX_TENS),
    .MAX_UNITS(MIN_MAX_UNITS)
  ) u_min_incr (
    .units     (o_Alarm_Units_Min),
    .tens      (o_Alarm_Tens_Min),
    .next_units(min_units_inc_s),
    .next_tens (min_tens_inc_s)
  );

  // Match level is state-independent so that a dismiss during second 00 cannot re-trigger.
  always_comb begin
    match_s = o_Alarm_Armed
            && (i_Tens_Hour  == o_Alarm_Tens_Hour)
            && (i_Units_Hour == o_Alarm_Units_Hour)
            && (i_Tens_Min   == o_Alarm_Tens_Min)
            && (i_Units_Min  == o_Alarm_Units_Min)
            && (i_Tens_Sec   == 3'd0)
            && (i_Units_Sec  == 4'd0);
    match_rise_s = match_s && !match_prev_r;
  end

  // Next-state, alarm register and counter logic.
  always_comb begin
    state_s      = state_r;
    idle_cnt_s   = idle_cnt_r;
    ring_cnt_s   = ring_cnt_r;
    snooze_cnt_s = snooze_cnt_r;
    armed_s      = o_Alarm_Armed;
    units_hour_s = o_Alarm_Units_Hour;
    tens_hour_s  = o_Alarm_Tens_Hour;
    units_min_s  = o_Alarm_Units_Min;
    tens_min_s   = o_Alarm_Tens_Min;

    if ((state_r != ST_IDLE) && !i_Clock_Mode_Idle) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_Released_Button_Alarm) begin
            if (i_Clock_Mode_Idle) begin
              state_s    = ST_SET_HOUR;
              idle_cnt_s = {IDLE_W{1'b0}};
            end else begin
              state_s = ST_IDLE;
            end
          end else if (i_Released_Button_Up) begin
            armed_s = !o_Alarm_Armed;
          end else if (match_rise_s) begin
            state_s    = ST_RING;
            ring_cnt_s = {RING_W{1'b0}};
          end else begin
            state_s = ST_IDLE;
          end
        end

        ST_SET_HOUR: begin
          if (i_Released_Button_Alarm) begin
            state_s    = ST_SET_MIN;
            idle_cnt_s = {IDLE_W{1'b0}};
          end else if (i_Released_Button_Up) begin
            units_hour_s = hour_units_inc_s;
            tens_hour_s  = hour_tens_inc_s;
            idle_cnt_s   = {IDLE_W{1'b0}};
          end else if (i_Enable_1Hz) begin
            if (idle_cnt_r >= IDLE_W'(SET_TIMEOUT_SEC - 1)) begin
              state_s    = ST_IDLE;
              idle_cnt_s = IDLE_W'(SET_TIMEOUT_SEC);
            end else begin
              idle_cnt_s = idle_cnt_r + {{(IDLE_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_s = ST_SET_HOUR;
          end
        end

        ST_SET_MIN: begin
          if (i_Released_Button_Alarm) begin
            state_s = ST_IDLE;
            armed_s = 1'b1;
          end else if (i_Released_Button_Up) begin
            units_min_s = min_units_inc_s;
            tens_min_s  = min_tens_inc_s;
            idle_cnt_s  = {IDLE_W{1'b0}};
          end else if (i_Enable_1Hz) begin
            if (idle_cnt_r >= IDLE_W'(SET_TIMEOUT_SEC - 1)) begin
              state_s    = ST_IDLE;
              idle_cnt_s = IDLE_W'(SET_TIMEOUT_SEC);
            end else begin
              idle_cnt_s = idle_cnt_r + {{(IDLE_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_s = ST_SET_MIN;
          end
        end

        ST_RING: begin
          if (i_Released_Button_Alarm) begin
            state_s = ST_IDLE;
          end else if (i_Released_Button_Up) begin
            state_s      = ST_SNOOZE;
            snooze_cnt_s = SNOOZE_W'(SNOOZE_SECONDS);
          end else if (i_Enable_1Hz) begin
            if (ring_cnt_r >= RING_W'(RING_SECONDS - 1)) begin
              state_s    = ST_IDLE;
              ring_cnt_s = RING_W'(RING_SECONDS);
            end else begin
              ring_cnt_s = ring_cnt_r + {{(RING_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_s = ST_RING;
          end
        end

        ST_SNOOZE: begin
          if (i_Released_Button_Alarm) begin
            state_s = ST_IDLE;
          end else if (i_Enable_1Hz) begin
            // The tick that brings the count to zero re-enters RING directly.
            if (snooze_cnt_r <= SNOOZE_W'(1)) begin
              state_s      = ST_RING;
              snooze_cnt_s = {SNOOZE_W{1'b0}};
              ring_cnt_s   = {RING_W{1'b0}};
            end else begin
              snooze_cnt_s = snooze_cnt_r - {{(SNOOZE_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_s = ST_SNOOZE;
          end
        end

        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters, alarm registers and registered display/buzzer outputs.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_r                 <= ST_IDLE;
      idle_cnt_r              <= {IDLE_W{1'b0}};
      ring_cnt_r              <= {RING_W{1'b0}};
      snooze_cnt_r            <= {SNOOZE_W{1'b0}};
      match_prev_r            <= 1'b0;
      o_Alarm_Armed           <= 1'b0;
      o_Alarm_Units_Hour      <= 4'd0;
      o_Alarm_Tens_Hour       <= 2'd0;
      o_Alarm_Units_Min       <= 4'd0;
      o_Alarm_Tens_Min        <= 3'd0;
      o_Display_Select_Alarm  <= 1'b0;
      o_Display_Enable_Digits <= DISP_NONE;
      o_Buzzer_Enable         <= 1'b0;
    end else begin
      state_r                 <= state_s;
      idle_cnt_r              <= idle_cnt_s;
      ring_cnt_r              <= ring_cnt_s;
      snooze_cnt_r            <= snooze_cnt_s;
      match_prev_r            <= match_s;
      o_Alarm_Armed           <= armed_s;
      o_Alarm_Units_Hour      <= units_hour_s;
      o_Alarm_Tens_Hour       <= tens_hour_s;
      o_Alarm_Units_Min       <= units_min_s;
      o_Alarm_Tens_Min        <= tens_min_s;
      o_Display_Select_Alarm  <= is_set_state(state_s);
      o_Display_Enable_Digits <= disp_mask(state_s);
      o_Buzzer_Enable         <= (state_s == ST_RING);
    end
  end

endmodule
